// File: rtl/pmu_pkg.sv
// Shared definitions for the CPU clock-gate power management unit:
// FSM state encoding, APB register offsets and register bit positions.
package pmu_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_ENTRY = 2'd1,
    ST_GATED = 2'd2,
    ST_EXIT  = 2'd3
  } pmu_state_e;

  localparam logic [3:0] OFF_CTRL      = 4'h0;
  localparam logic [3:0] OFF_ENTRY_DLY = 4'h4;
  localparam logic [3:0] OFF_WAKE_TMR  = 4'h8;
  localparam logic [3:0] OFF_STATUS    = 4'hC;

  localparam int CTRL_GATE_EN     = 0;
  localparam int CTRL_TMR_WAKE_EN = 1;
  localparam int CTRL_IRQ_EN      = 2;

  localparam int STAT_WK_IRQ = 2;
  localparam int STAT_WK_TMR = 3;

endpackage

// File: rtl/pmu_down_counter.sv
// Loadable down counter that stops at zero. Load has priority over decrement.
module pmu_down_counter #(
  parameter int W = 8
) (
  input  logic         per_clk,
  input  logic         clkrst_b,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] value,
  output logic         is_zero
);

  // Count register: load a new value or step down, never wrapping below zero.
  always_ff @(posedge per_clk or negedge clkrst_b) begin
    if (!clkrst_b) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (dec && (value != '0)) begin
      value <= value - W'(1);
    end
  end

  assign is_zero = (value == '0);

endmodule

// File: rtl/pmu_gate_ctrl.sv
// CPU clock-gate controller: gates the CPU clock after a programmable delay once
// the core sleeps, and ungates on an interrupt wake request or a wake timer.
// Runs on the ungated peripheral clock; configured through a zero-wait APB slave.
module pmu_gate_ctrl
  import pmu_pkg::*;
#(
  parameter int EXIT_CYC = 2,
  parameter int DLY_W    = 8,
  parameter int TMR_W    = 16
) (
  input  logic        per_clk,
  input  logic        clkrst_b,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [3:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  input  logic        cpu_sleep,
  input  logic        wake_req,
  output logic        gate_en0,
  output logic        pmu_irq,
  output logic [1:0]  pmu_state
);

  localparam int EXIT_W = 4;

  logic [2:0]       ctrl;
  logic [DLY_W-1:0] entry_dly;
  logic [TMR_W-1:0] wake_tmr;
  logic             wk_irq;
  logic             wk_tmr;
  logic             armed;

  pmu_state_e state;
  pmu_state_e state_nxt;

  logic entry_load, entry_dec, entry_zero;
  logic wake_load, wake_dec, wake_zero;
  logic exit_load, exit_dec, exit_zero;
  logic set_wk_irq, set_wk_tmr;

  logic [DLY_W-1:0]  entry_val;
  logic [TMR_W-1:0]  wake_val;
  logic [EXIT_W-1:0] exit_val;

  logic wr_en;
  logic clr_stat;

  assign wr_en     = psel & penable & pwrite;
  assign clr_stat  = wr_en && (paddr == OFF_STATUS);
  assign pmu_state = state;

  pmu_down_counter #(.W(DLY_W)) u_entry_cnt (
    .per_clk (per_clk),
    .clkrst_b(clkrst_b),
    .load    (entry_load),
    .load_val(entry_dly),
    .dec     (entry_dec),
    .value   (entry_val),
    .is_zero (entry_zero)
  );

  pmu_down_counter #(.W(TMR_W)) u_wake_cnt (
    .per_clk (per_clk),
    .clkrst_b(clkrst_b),
    .load    (wake_load),
    .load_val(wake_tmr),
    .dec     (wake_dec),
    .value   (wake_val),
    .is_zero (wake_zero)
  );

  pmu_down_counter #(.W(EXIT_W)) u_exit_cnt (
    .per_clk (per_clk),
    .clkrst_b(clkrst_b),
    .load    (exit_load),
    .load_val(EXIT_W'(EXIT_CYC - 1)),
    .dec     (exit_dec),
    .value   (exit_val),
    .is_zero (exit_zero)
  );

  // Counter values are only consumed through their zero flags.
  logic unused_sig;
  assign unused_sig = ^{entry_val, wake_val, exit_val, pwdata};

  // Next-state logic; counters are loaded only on state transitions.
  always_comb begin
    state_nxt  = state;
    entry_load = 1'b0;
    entry_dec  = 1'b0;
    wake_load  = 1'b0;
    wake_dec   = 1'b0;
    exit_load  = 1'b0;
    exit_dec   = 1'b0;
    set_wk_irq = 1'b0;
    set_wk_tmr = 1'b0;
    case (state)
      ST_RUN: begin
        if (cpu_sleep && ctrl[CTRL_GATE_EN] && !wake_req && armed) begin
          state_nxt  = ST_ENTRY;
          entry_load = 1'b1;
        end
      end
      ST_ENTRY: begin
        if (!cpu_sleep || wake_req) begin
          state_nxt = ST_RUN;
        end else if (entry_zero) begin
          state_nxt = ST_GATED;
          wake_load = 1'b1;
        end else begin
          entry_dec = 1'b1;
        end
      end
      ST_GATED: begin
        set_wk_irq = wake_req;
        set_wk_tmr = ctrl[CTRL_TMR_WAKE_EN] && wake_zero;
        if (set_wk_irq || set_wk_tmr) begin
          state_nxt = ST_EXIT;
          exit_load = 1'b1;
        end else begin
          wake_dec = 1'b1;
        end
      end
      ST_EXIT: begin
        if (exit_zero) begin
          state_nxt = ST_RUN;
        end else begin
          exit_dec = 1'b1;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // State, registered gate enable, re-arm flag and interrupt output.
  always_ff @(posedge per_clk or negedge clkrst_b) begin
    if (!clkrst_b) begin
      state    <= ST_RUN;
      gate_en0 <= 1'b1;
      armed    <= 1'b1;
      pmu_irq  <= 1'b0;
    end else begin
      state    <= state_nxt;
      gate_en0 <= (state_nxt != ST_GATED);
      // An awake core re-arms; leaving EXIT with the core still asleep disarms.
      if (!cpu_sleep) begin
        armed <= 1'b1;
      end else if ((state == ST_EXIT) && exit_zero) begin
        armed <= 1'b0;
      end
      pmu_irq  <= ctrl[CTRL_IRQ_EN] & (wk_irq | wk_tmr);
    end
  end

  // APB writable registers; a hardware status set beats a same-cycle W1C.
  always_ff @(posedge per_clk or negedge clkrst_b) begin
    if (!clkrst_b) begin
      ctrl      <= '0;
      entry_dly <= '0;
      wake_tmr  <= '0;
      wk_irq    <= 1'b0;
      wk_tmr    <= 1'b0;
    end else begin
      if (wr_en && (paddr == OFF_CTRL))      ctrl      <= pwdata[2:0];
      if (wr_en && (paddr == OFF_ENTRY_DLY)) entry_dly <= pwdata[DLY_W-1:0];
      if (wr_en && (paddr == OFF_WAKE_TMR))  wake_tmr  <= pwdata[TMR_W-1:0];
      wk_irq <= set_wk_irq | (wk_irq & ~(clr_stat & pwdata[STAT_WK_IRQ]));
      wk_tmr <= set_wk_tmr | (wk_tmr & ~(clr_stat & pwdata[STAT_WK_TMR]));
    end
  end

  // Combinational read mux; idle bus and unmapped offsets read zero.
  always_comb begin
    prdata = '0;
    if (psel && !pwrite) begin
      case (paddr)
        OFF_CTRL:      prdata = {29'd0, ctrl};
        OFF_ENTRY_DLY: prdata = {{(32-DLY_W){1'b0}}, entry_dly};
        OFF_WAKE_TMR:  prdata = {{(32-TMR_W){1'b0}}, wake_tmr};
        OFF_STATUS:    prdata = {28'd0, wk_tmr, wk_irq, state};
        default:       prdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_pmu_gate_ctrl.sv
// Self-checking bench for pmu_gate_ctrl: per-cycle stimulus/expectation
// scoreboard for FSM traces, plus queued expected APB read data.
module tb_pmu_gate_ctrl;

  logic        per_clk  = 1'b0;
  logic        clkrst_b = 1'b0;
  logic        psel     = 1'b0;
  logic        penable  = 1'b0;
  logic        pwrite   = 1'b0;
  logic [3:0]  paddr    = 4'h0;
  logic [31:0] pwdata   = 32'h0;
  logic [31:0] prdata;
  logic        cpu_sleep = 1'b0;
  logic        wake_req  = 1'b0;
  logic        gate_en0;
  logic        pmu_irq;
  logic [1:0]  pmu_state;

  int total = 0;
  int bad   = 0;

  // One scoreboard step: inputs to drive, then the state/gate expected after the edge.
  typedef struct packed {
    logic       slp;
    logic       wk;
    logic [1:0] st;
    logic       g;
  } step_t;

  step_t       exp_q[$];
  logic [31:0] rd_q[$];

  always #5 per_clk = ~per_clk;

  pmu_gate_ctrl dut (
    .per_clk  (per_clk),
    .clkrst_b (clkrst_b),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .prdata   (prdata),
    .cpu_sleep(cpu_sleep),
    .wake_req (wake_req),
    .gate_en0 (gate_en0),
    .pmu_irq  (pmu_irq),
    .pmu_state(pmu_state)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge per_clk);
  endtask

  function automatic void push(logic s, logic w, logic [1:0] st, logic g, int n);
    for (int i = 0; i < n; i++) exp_q.push_back('{slp: s, wk: w, st: st, g: g});
  endfunction

  task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
    psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d; penable = 1'b0;
    tick();
    penable = 1'b1;
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] a, output logic [31:0] d);
    psel = 1'b1; pwrite = 1'b0; paddr = a; penable = 1'b0;
    #1;
    d = prdata;
    psel = 1'b0;
  endtask

  task automatic do_reset();
    clkrst_b = 1'b0; cpu_sleep = 1'b0; wake_req = 1'b0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    repeat (2) tick();
    clkrst_b = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    clkrst_b = 1'b0;
    repeat (2) tick();
    total++; if (gate_en0 !== 1'b1) begin bad++; $display("FAIL reset_gate got=%b want=1", gate_en0); end
    total++; if (pmu_irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", pmu_irq); end
    total++; if (pmu_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", pmu_state); end
    clkrst_b = 1'b1;
    tick();
  endtask

  task automatic test_regs();
    logic [31:0] d, e;
    logic [3:0]  a;
    do_reset();
    apb_write(4'h0, 32'hFFFF_FFFF);
    apb_write(4'h4, 32'hFFFF_FFFF);
    apb_write(4'h8, 32'hFFFF_FFFF);
    apb_write(4'h2, 32'hFFFF_FFFF);
    apb_write(4'hC, 32'hFFFF_FFFF);
    rd_q.push_back(32'h7); rd_q.push_back(32'hFF); rd_q.push_back(32'hFFFF);
    rd_q.push_back(32'h0); rd_q.push_back(32'h0);
    for (int i = 0; i < 5; i++) begin
      a = (i == 3) ? 4'h2 : ((i == 4) ? 4'hC : 4'(i * 4));
      apb_read(a, d);
      e = rd_q.pop_front();
      total++; if (d !== e) begin bad++; $display("FAIL regs_rd addr=%h got=%h want=%h", a, d, e); end
    end
    psel = 1'b0; paddr = 4'h0; #1;
    total++; if (prdata !== 32'h0) begin bad++; $display("FAIL regs_idle got=%h want=0", prdata); end
    tick();
  endtask

  task automatic test_entry();
    step_t e;
    do_reset();
    apb_write(4'h0, 32'h1);
    apb_write(4'h4, 32'h3);
    push(1, 0, 2'd1, 1, 4);
    push(1, 0, 2'd2, 0, 3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cpu_sleep = e.slp; wake_req = e.wk;
      tick();
      total++; if ({pmu_state, gate_en0} !== {e.st, e.g}) begin bad++;
        $display("FAIL entry_trace state/gate got=%0d/%b want=%0d/%b", pmu_state, gate_en0, e.st, e.g); end
    end
  endtask

  task automatic test_irq_wake();
    step_t e;
    logic [31:0] d, x;
    apb_write(4'h0, 32'h5);
    push(1, 1, 2'd3, 1, 1);
    push(0, 0, 2'd3, 1, 1);
    push(0, 0, 2'd0, 1, 2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cpu_sleep = e.slp; wake_req = e.wk;
      tick();
      total++; if ({pmu_state, gate_en0} !== {e.st, e.g}) begin bad++;
        $display("FAIL irq_trace state/gate got=%0d/%b want=%0d/%b", pmu_state, gate_en0, e.st, e.g); end
    end
    rd_q.push_back(32'h4);
    apb_read(4'hC, d); x = rd_q.pop_front();
    total++; if (d !== x) begin bad++; $display("FAIL irq_status got=%h want=%h", d, x); end
    total++; if (pmu_irq !== 1'b1) begin bad++; $display("FAIL irq_level got=%b want=1", pmu_irq); end
    tick();
    apb_write(4'hC, 32'h4);
    tick();
    total++; if (pmu_irq !== 1'b0) begin bad++; $display("FAIL irq_clear got=%b want=0", pmu_irq); end
    rd_q.push_back(32'h0);
    apb_read(4'hC, d); x = rd_q.pop_front();
    total++; if (d !== x) begin bad++; $display("FAIL irq_status_clr got=%h want=%h", d, x); end
    tick();
  endtask

  task automatic test_tmr_wake();
    step_t e;
    logic [31:0] d, x;
    do_reset();
    apb_write(4'h0, 32'h3);
    apb_write(4'h8, 32'h5);
    apb_write(4'h4, 32'h0);
    push(1, 0, 2'd1, 1, 1);
    push(1, 0, 2'd2, 0, 6);
    push(1, 0, 2'd3, 1, 2);
    push(1, 0, 2'd0, 1, 4);
    push(0, 0, 2'd0, 1, 1);
    push(1, 0, 2'd1, 1, 1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cpu_sleep = e.slp; wake_req = e.wk;
      tick();
      total++; if ({pmu_state, gate_en0} !== {e.st, e.g}) begin bad++;
        $display("FAIL tmr_trace state/gate got=%0d/%b want=%0d/%b", pmu_state, gate_en0, e.st, e.g); end
    end
    rd_q.push_back(32'h9);
    apb_read(4'hC, d); x = rd_q.pop_front();
    total++; if (d !== x) begin bad++; $display("FAIL tmr_status got=%h want=%h", d, x); end
    total++; if (pmu_irq !== 1'b0) begin bad++; $display("FAIL tmr_irq_masked got=%b want=0", pmu_irq); end
    tick();
  endtask

  task automatic test_entry_abort();
    step_t e;
    logic [31:0] d, x;
    do_reset();
    apb_write(4'h0, 32'h1);
    apb_write(4'h4, 32'd10);
    push(1, 0, 2'd1, 1, 4);
    push(0, 0, 2'd0, 1, 3);
    push(1, 0, 2'd1, 1, 1);
    push(1, 1, 2'd0, 1, 2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cpu_sleep = e.slp; wake_req = e.wk;
      tick();
      total++; if ({pmu_state, gate_en0} !== {e.st, e.g}) begin bad++;
        $display("FAIL abort_trace state/gate got=%0d/%b want=%0d/%b", pmu_state, gate_en0, e.st, e.g); end
    end
    rd_q.push_back(32'h0);
    apb_read(4'hC, d); x = rd_q.pop_front();
    total++; if (d !== x) begin bad++; $display("FAIL abort_status got=%h want=%h", d, x); end
    tick();
  endtask

  task automatic test_same_cycle();
    step_t e;
    logic [31:0] d, x;
    do_reset();
    apb_write(4'h0, 32'h3);
    apb_write(4'h8, 32'h2);
    apb_write(4'h4, 32'h0);
    push(1, 0, 2'd1, 1, 1);
    push(1, 0, 2'd2, 0, 3);
    push(1, 1, 2'd3, 1, 1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cpu_sleep = e.slp; wake_req = e.wk;
      // APB setup lands on the last GATED cycle so its access phase meets the wake edge.
      if (exp_q.size() == 1) begin psel = 1'b1; pwrite = 1'b1; paddr = 4'hC; pwdata = 32'hC; penable = 1'b0; end
      if (exp_q.size() == 0) penable = 1'b1;
      tick();
      total++; if ({pmu_state, gate_en0} !== {e.st, e.g}) begin bad++;
        $display("FAIL same_trace state/gate got=%0d/%b want=%0d/%b", pmu_state, gate_en0, e.st, e.g); end
    end
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; cpu_sleep = 1'b0; wake_req = 1'b0;
    rd_q.push_back(32'hF);
    apb_read(4'hC, d); x = rd_q.pop_front();
    total++; if (d !== x) begin bad++; $display("FAIL same_status got=%h want=%h", d, x); end
    repeat (2) tick();
    apb_write(4'hC, 32'h8);
    rd_q.push_back(32'h4);
    apb_read(4'hC, d); x = rd_q.pop_front();
    total++; if (d !== x) begin bad++; $display("FAIL same_w1c got=%h want=%h", d, x); end
    tick();
  endtask

  task automatic test_async_reset();
    step_t e;
    logic [31:0] d, x;
    do_reset();
    apb_write(4'h0, 32'h7);
    apb_write(4'h8, 32'h1234);
    apb_write(4'h4, 32'h0);
    push(1, 0, 2'd1, 1, 1);
    push(1, 0, 2'd2, 0, 1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cpu_sleep = e.slp; wake_req = e.wk;
      tick();
      total++; if ({pmu_state, gate_en0} !== {e.st, e.g}) begin bad++;
        $display("FAIL arst_trace state/gate got=%0d/%b want=%0d/%b", pmu_state, gate_en0, e.st, e.g); end
    end
    #2 clkrst_b = 1'b0;
    #1;
    total++; if (gate_en0 !== 1'b1) begin bad++; $display("FAIL arst_gate got=%b want=1", gate_en0); end
    total++; if (pmu_state !== 2'd0) begin bad++; $display("FAIL arst_state got=%0d want=0", pmu_state); end
    cpu_sleep = 1'b0;
    tick();
    clkrst_b = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      rd_q.push_back(32'h0);
      apb_read(4'(i * 4), d); x = rd_q.pop_front();
      total++; if (d !== x) begin bad++; $display("FAIL arst_reg addr=%h got=%h want=%h", 4'(i * 4), d, x); end
    end
    total++; if (pmu_irq !== 1'b0) begin bad++; $display("FAIL arst_irq got=%b want=0", pmu_irq); end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_entry();
    test_irq_wake();
    test_tmr_wake();
    test_entry_abort();
    test_same_cycle();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
